// File: rtl/hex_display_scan.sv
// Four-digit multiplexed 7-segment driver with per-frame snapshot, inter-digit blanking, decimal point and blink.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zeros on digits 3 and 2.
module hex_display_scan #(
    parameter int IN_CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_HZ     = 2,
    parameter int DP_POS       = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic       clk,
    input  logic       key_reset_n,
    input  logic [3:0] Hex_0,
    input  logic [3:0] Hex_1,
    input  logic [3:0] Hex_2,
    input  logic [3:0] Hex_3,
    input  logic       dp_en,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int SCAN_DIV   = IN_CLK_HZ / SCAN_HZ;
    localparam int BLINK_HALF = IN_CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM  = CNT_W'(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [1:0]       DP_IDX     = 2'(DP_POS);
    localparam logic             OFF        = (ACTIVE_LOW != 0);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_blank
        $error("hex_display_scan: BLANK_CYCLES must be in 0..SCAN_DIV-1");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("hex_display_scan: blink half-period must be at least one cycle");
    end
    if (DP_POS < 0 || DP_POS > 3) begin : g_bad_dp
        $error("hex_display_scan: DP_POS must be in 0..3");
    end

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       digit_idx;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;
    logic [15:0]      snap;

    logic             load_snap;
    logic [15:0]      snap_view;
    logic [0:0]       slot_state;
    logic [3:0]       digit_val;
    logic             digit_blanked;
    logic             show_digit;
    logic [3:0]       an_on;
    logic [6:0]       seg_on;
    logic             dp_on;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    // The snapshot is taken on the first cycle of every digit-0 slot; the
    // freshly sampled value is forwarded so that cycle already uses it.
    assign load_snap  = (digit_idx == 2'd0) && (slot_cnt == '0);
    assign snap_view  = load_snap ? {Hex_3, Hex_2, Hex_1, Hex_0} : snap;
    assign slot_state = (slot_cnt < BLANK_LIM) ? ST_BLANK : ST_SHOW;
    assign digit_val  = snap_view[{digit_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        // NOTE: assign a default before any branch so no latch is inferred.
        digit_blanked = 1'b0;
        if (digit_idx == 2'd3) begin
            digit_blanked = (snap_view[15:12] == 4'h0);
        end else if (digit_idx == 2'd2 && DP_POS != 2) begin
            digit_blanked = (snap_view[15:8] == 8'h00);
        end
    end
`else
    assign digit_blanked = 1'b0;
`endif

    assign show_digit = (slot_state == ST_SHOW) && !digit_blanked && !(blink && blink_phase);
    assign an_on      = show_digit ? (4'b0001 << digit_idx) : 4'b0000;
    assign seg_on     = show_digit ? hex_to_seg(digit_val) : 7'b0000000;
    assign dp_on      = show_digit && (digit_idx == DP_IDX) && dp_en;

    // Snapshot is cleared on reset so the very first frame never shows
    // undefined digits, even if BLANK_CYCLES is zero.
    always_ff @(posedge clk or negedge key_reset_n) begin
        if (!key_reset_n) begin
            slot_cnt    <= '0;
            digit_idx   <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            snap        <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (slot_cnt == SCAN_LAST) begin
                slot_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            if (load_snap) begin
                snap <= {Hex_3, Hex_2, Hex_1, Hex_0};
            end
        end
    end

    // Pin drivers are registered; polarity is folded in at the flop input.
    always_ff @(posedge clk or negedge key_reset_n) begin
        if (!key_reset_n) begin
            an          <= {4{OFF}};
            seg         <= {7{OFF}};
            dp          <= OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_on ^ {4{OFF}};
            seg         <= seg_on ^ {7{OFF}};
            dp          <= dp_on ^ OFF;
            frame_start <= load_snap;
        end
    end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Display-side consumer of the four 4-bit digit buses produced by the stopwatch/clock blocks.
- Time-multiplexes the four digits onto one shared 7-segment bus with one-hot digit enables.
- Adds inter-digit blanking, per-frame snapshot (no tearing), decimal point and blink.
- Sits between the timekeeping logic and the board's 4-digit common-anode display pins.

Parameters:
- IN_CLK_HZ, 50_000_000: input clock frequency.
- SCAN_HZ, 1000: digit-slot rate; SCAN_DIV = IN_CLK_HZ/SCAN_HZ cycles per slot.
- BLANK_CYCLES, 16: cycles at start of each slot with all digit enables inactive (anti-ghosting); must be < SCAN_DIV (elaboration error otherwise).
- BLINK_HZ, 2: blink rate; half-period = IN_CLK_HZ/(2*BLINK_HZ) cycles.
- DP_POS, 2: digit index (0..3) whose decimal point lights when dp_en=1.
- ACTIVE_LOW, 1: 1 = seg, dp, an are active-low; 0 = active-high.

Ports:
- clk  in  1  system clock
- key_reset_n  in  1  asynchronous reset, active-low
- Hex_0  in  4  digit 0 (rightmost) value
- Hex_1  in  4  digit 1 value
- Hex_2  in  4  digit 2 value
- Hex_3  in  4  digit 3 (leftmost) value
- dp_en  in  1  enable decimal point on digit DP_POS
- blink  in  1  1 = blank whole display during odd blink phase
- seg  out  7  segments, bit0=a .. bit6=g
- dp  out  1  decimal point segment
- an  out  4  one-hot digit enable, bit i = digit i
- frame_start  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Reset, async on key_reset_n=0: an/seg/dp all inactive level; frame_start=0; slot counter, digit index, blink counter/phase = 0; snapshot = 0. Release synchronous to clk.
- Slot counter runs 0..SCAN_DIV-1, then wraps; on wrap, digit index advances 0->1->2->3->0.
- FSM per slot: BLANK (count < BLANK_CYCLES) -> SHOW (remainder). In BLANK, an all inactive and seg/dp inactive. In SHOW, an drives only the current index active.
- Snapshot: on the cycle the index changes 3->0 (and on first slot after reset), all four Hex_* inputs are registered together; the whole frame displays the snapshot. Input changes mid-frame appear from the next frame.
- frame_start = 1 for exactly the first cycle of each digit-0 slot.
- Decoder: full hex 0-F; 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,B=7C,C=39,D=5E,E=79,F=71 (active-high gfedcba), inverted when ACTIVE_LOW=1.
- dp active only in SHOW of digit DP_POS with dp_en=1; dp_en sampled live.
- Blink: free-running counter toggles phase each half-period. blink=1 and phase=1 forces an all inactive. blink sampled live; deassert restores normal output next cycle.
- All outputs registered: output reflects counter state with 1 cycle latency.
- Reset mid-frame: outputs inactive immediately; scan restarts at digit 0 BLANK after release.

Optional Feature:
- LEADING_ZERO_BLANK_EN defined: digit 3 blanked (an stays inactive in its SHOW) when snapshot Hex_3=0; digit 2 also blanked when Hex_3=0 and Hex_2=0 and DP_POS!=2. Digits 1 and 0 are never blanked.
- Not defined: all four digits always shown.

Test Plan:
- Sim params IN_CLK_HZ=40, SCAN_HZ=4 (SCAN_DIV=10), BLANK_CYCLES=2, BLINK_HZ=1, ACTIVE_LOW=1.
- Reset release, Hex_3..0 = 1,2,3,4 -> an=1111 for 2 cycles, then an=1110 seg=~7'h66 for 8 cycles, then digit1 seg=~7'h4F; frame_start pulses every 40 cycles.
- Hex_0 changes 4->9 during digit-2 slot -> digit 0 still shows 4 in the current frame; shows ~7'h6F from the next frame.
- dp_en=1, DP_POS=2 -> dp=0 only during digit-2 SHOW cycles; dp=1 elsewhere, including BLANK.
- blink=1 -> an=1111 for 20-cycle windows alternating with 20-cycle normal scan; blink=0 -> normal on next cycle.
- key_reset_n low mid-SHOW of digit 1 -> an=1111, seg=7'h7F same cycle; after release, scan restarts at digit-0 BLANK.
- Hex_3=0, Hex_2=0, macro defined, DP_POS=1 -> digits 3 and 2 never enabled; macro undefined -> both show ~7'h3F.
